// File: rtl/priority_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : priority_request_scheduler
//  Purpose  : Front stage for a 4-input priority encoder. Rising edges on
//             p3..p0 set sticky pending bits. The highest-priority pending
//             channel is offered downstream over a valid/ready handshake.
//             An offer is held stable until it is accepted, and there is no
//             preemption. Each channel has a saturating service counter.
//             Priority order: p3 highest, p0 lowest.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             p3..p0             - request lines
//             y_valid/y_ready    - offer handshake
//             y_idx, y_onehot    - offered channel (one-hot is 0 when idle)
//             pending            - sticky pending bits {p3,p2,p1,p0}
//             cnt_sel, cnt_out   - read mux over the per-channel counters
//  Revision : 1.0 - initial release
// ============================================================================
module priority_request_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p3,
    input  logic             p2,
    input  logic             p1,
    input  logic             p0,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [1:0]       y_idx,
    output logic [3:0]       y_onehot,
    output logic [3:0]       pending,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t           r_state_q,    w_state_d;
    logic [3:0]       r_prev_q,     w_prev_d;
    logic [3:0]       r_pending_q,  w_pending_d;
    logic             r_y_valid_q,  w_y_valid_d;
    logic [1:0]       r_y_idx_q,    w_y_idx_d;
    logic [3:0]       r_y_onehot_q, w_y_onehot_d;
    logic [CNT_W-1:0] r_cnt_q [4];
    logic [CNT_W-1:0] w_cnt_d [4];

    logic [3:0] w_req;
    logic [3:0] w_rise;
    logic [3:0] w_clr;

    always_comb begin
        w_req        = {p3, p2, p1, p0};
        // A rise re-arms a channel; a level held high never re-requests.
        w_rise       = w_req & ~r_prev_q;
        w_prev_d     = w_req;
        w_state_d    = r_state_q;
        w_y_valid_d  = r_y_valid_q;
        w_y_idx_d    = r_y_idx_q;
        w_y_onehot_d = r_y_onehot_q;
        w_clr        = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_cnt_d[i] = r_cnt_q[i];
        end

        case (r_state_q)
            ST_IDLE: begin
                if (r_pending_q != 4'b0000) begin
                    if (r_pending_q[3])      w_y_idx_d = 2'd3;
                    else if (r_pending_q[2]) w_y_idx_d = 2'd2;
                    else if (r_pending_q[1]) w_y_idx_d = 2'd1;
                    else                     w_y_idx_d = 2'd0;
                    w_y_onehot_d = 4'b0001 << w_y_idx_d;
                    w_y_valid_d  = 1'b1;
                    w_state_d    = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // The offer is frozen until accepted; new requests only
                // accumulate in the pending bits.
                if (y_ready) begin
                    w_clr[r_y_idx_q] = 1'b1;
                    if (r_cnt_q[r_y_idx_q] != c_cnt_max) begin
                        w_cnt_d[r_y_idx_q] = r_cnt_q[r_y_idx_q] + CNT_W'(1);
                    end
                    w_y_valid_d  = 1'b0;
                    w_y_onehot_d = 4'b0000;
                    w_state_d    = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // The set term is OR-ed last so that a rise on the edge where the
        // same channel is accepted survives as a fresh request.
        w_pending_d = (r_pending_q & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_prev_q     <= 4'b0000;
            r_pending_q  <= 4'b0000;
            r_y_valid_q  <= 1'b0;
            r_y_idx_q    <= 2'd0;
            r_y_onehot_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_cnt_q[i] <= '0;
            end
        end else begin
            r_state_q    <= w_state_d;
            r_prev_q     <= w_prev_d;
            r_pending_q  <= w_pending_d;
            r_y_valid_q  <= w_y_valid_d;
            r_y_idx_q    <= w_y_idx_d;
            r_y_onehot_q <= w_y_onehot_d;
            for (int i = 0; i < 4; i++) begin
                r_cnt_q[i] <= w_cnt_d[i];
            end
        end
    end

    assign y_valid  = r_y_valid_q;
    assign y_idx    = r_y_idx_q;
    assign y_onehot = r_y_onehot_q;
    assign pending  = r_pending_q;
    assign cnt_out  = r_cnt_q[cnt_sel];

endmodule
`default_nettype wire

// File: tb/tb_priority_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_priority_request_scheduler
//  Purpose  : Directed testbench for priority_request_scheduler. The DUT is
//             built with CNT_W=2 so that counter saturation can be reached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_priority_request_scheduler;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             p3, p2, p1, p0;
    logic             y_valid;
    logic             y_ready;
    logic [1:0]       y_idx;
    logic [3:0]       y_onehot;
    logic [3:0]       pending;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    int checks = 0;
    int errors = 0;
    int offers;

    priority_request_scheduler #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .p3       (p3),
        .p2       (p2),
        .p1       (p1),
        .p0       (p0),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_idx    (y_idx),
        .y_onehot (y_onehot),
        .pending  (pending),
        .cnt_sel  (cnt_sel),
        .cnt_out  (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        cnt_sel = sel;
        #1;
        chk(tag, 32'(cnt_out), exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {p3, p2, p1, p0} = 4'b0000;
        y_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {p3, p2, p1, p0} = 4'b1111;
        y_ready = 1'b0;
        cnt_sel = 2'd0;

        // ---- Reset with all inputs high ----
        step();
        step();
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_valid",   32'(y_valid), 32'h0);
        chk("rst_onehot",  32'(y_onehot), 32'h0);
        chk("rst_idx",     32'(y_idx), 32'h0);
        for (int i = 0; i < 4; i++) chk_cnt("rst_cnt", 2'(i), 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_pending", 32'(pending), 32'hF);
        chk("post_rst_valid",   32'(y_valid), 32'h0);
        step();
        chk("post_rst_offer_valid",  32'(y_valid), 32'h1);
        chk("post_rst_offer_idx",    32'(y_idx), 32'h3);
        chk("post_rst_offer_onehot", 32'(y_onehot), 32'h8);

        // ---- Priority order: p2,p1,p0 pulsed together ----
        do_reset();
        {p2, p1, p0} = 3'b111;
        y_ready = 1'b1;
        step();
        chk("prio_pending", 32'(pending), 32'h7);
        {p2, p1, p0} = 3'b000;
        step();
        chk("prio_off1_idx", 32'(y_idx), 32'h2);
        chk("prio_off1_oh",  32'(y_onehot), 32'h4);
        step();
        chk("prio_acc1_valid",   32'(y_valid), 32'h0);
        chk("prio_acc1_onehot",  32'(y_onehot), 32'h0);
        chk("prio_acc1_pending", 32'(pending), 32'h3);
        step();
        chk("prio_off2_valid", 32'(y_valid), 32'h1);
        chk("prio_off2_idx",   32'(y_idx), 32'h1);
        step();
        step();
        chk("prio_off3_valid", 32'(y_valid), 32'h1);
        chk("prio_off3_idx",   32'(y_idx), 32'h0);
        step();
        chk("prio_final_pending", 32'(pending), 32'h0);
        chk("prio_final_valid",   32'(y_valid), 32'h0);
        chk_cnt("prio_cnt0", 2'd0, 32'h1);
        chk_cnt("prio_cnt1", 2'd1, 32'h1);
        chk_cnt("prio_cnt2", 2'd2, 32'h1);
        chk_cnt("prio_cnt3", 2'd3, 32'h0);

        // ---- Hold, no preemption ----
        do_reset();
        p1 = 1'b1;
        step();
        p1 = 1'b0;
        step();
        chk("hold_off_idx", 32'(y_idx), 32'h1);
        p3 = 1'b1;
        step();
        p3 = 1'b0;
        chk("hold_pending", 32'(pending), 32'hA);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_idx",   32'(y_idx), 32'h1);
            chk("hold_valid", 32'(y_valid), 32'h1);
        end
        y_ready = 1'b1;
        step();
        chk("hold_acc_valid",   32'(y_valid), 32'h0);
        chk("hold_acc_pending", 32'(pending), 32'h8);
        chk_cnt("hold_cnt1", 2'd1, 32'h1);
        step();
        chk("hold_next_valid", 32'(y_valid), 32'h1);
        chk("hold_next_idx",   32'(y_idx), 32'h3);

        // ---- Re-request on the acceptance edge ----
        do_reset();
        p2 = 1'b1;
        step();
        p2 = 1'b0;
        step();
        chk("rereq_off1_idx", 32'(y_idx), 32'h2);
        y_ready = 1'b1;
        p2 = 1'b1;
        step();
        p2 = 1'b0;
        chk("rereq_acc_valid",   32'(y_valid), 32'h0);
        chk("rereq_acc_pending", 32'(pending), 32'h4);
        step();
        chk("rereq_off2_valid", 32'(y_valid), 32'h1);
        chk("rereq_off2_idx",   32'(y_idx), 32'h2);
        step();
        chk("rereq_final_pending", 32'(pending), 32'h0);
        chk_cnt("rereq_cnt2", 2'd2, 32'h2);

        // ---- Level vs edge ----
        do_reset();
        y_ready = 1'b1;
        p0 = 1'b1;
        offers = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (y_valid) offers++;
        end
        chk("level_offers", 32'(offers), 32'h1);
        chk_cnt("level_cnt0_a", 2'd0, 32'h1);
        p0 = 1'b0;
        step();
        p0 = 1'b1;
        offers = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (y_valid) offers++;
        end
        chk("level_reoffers", 32'(offers), 32'h1);
        chk_cnt("level_cnt0_b", 2'd0, 32'h2);
        p0 = 1'b0;

        // ---- Counter saturation (CNT_W=2) ----
        do_reset();
        y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            p1 = 1'b1;
            step();
            p1 = 1'b0;
            step();
            step();
        end
        chk("sat_pending", 32'(pending), 32'h0);
        chk_cnt("sat_cnt1", 2'd1, 32'h3);

        // ---- Reset mid-offer ----
        do_reset();
        p2 = 1'b1;
        step();
        p2 = 1'b0;
        step();
        chk("midrst_valid_before", 32'(y_valid), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid",   32'(y_valid), 32'h0);
        chk("midrst_pending", 32'(pending), 32'h0);
        chk("midrst_onehot",  32'(y_onehot), 32'h0);
        for (int i = 0; i < 4; i++) chk_cnt("midrst_cnt", 2'(i), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
